// File: rtl/ring_buffer_mem.sv
// rtl/ring_buffer_mem.sv - simple dual-port RAM, one write port and one registered read port
module ring_buffer_mem #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage is never cleared so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ring_buffer.sv
// rtl/ring_buffer.sv - single-clock circular FIFO with one slot sacrificed to tell full from empty
module ring_buffer #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] write_data,
    input  logic          write_clock_enable,
    output logic [DW-1:0] read_data,
    input  logic          read_clock_enable,
    output logic          empty,
    output logic          overflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic          wr_accept;
    logic          rd_accept;

    assign wr_ptr_next = wr_ptr + 1'b1;
    assign empty       = (wr_ptr == rd_ptr);
    assign overflow    = (wr_ptr_next == rd_ptr);

    // Both requests judge the pre-edge flags, so a read on empty never bypasses a same-cycle write.
    assign wr_accept = write_clock_enable && !overflow && reset;
    assign rd_accept = read_clock_enable && !empty && reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    ring_buffer_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (write_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_ring_buffer.sv
// tb/tb_ring_buffer.sv - randomized and directed bench for ring_buffer against an occupancy-queue model
module tb_ring_buffer;

    localparam int AW  = 2;
    localparam int DW  = 2;
    localparam int CAP = (1 << AW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_clock_enable = 1'b0;
    logic [DW-1:0] read_data;
    logic          read_clock_enable = 1'b0;
    logic          empty;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] last_read = '0;
    int            wp = 0;
    int            rp = 0;

    ring_buffer #(.AW(AW), .DW(DW)) dut (
        .clock              (clock),
        .reset              (reset),
        .write_data         (write_data),
        .write_clock_enable (write_clock_enable),
        .read_data          (read_data),
        .read_clock_enable  (read_clock_enable),
        .empty              (empty),
        .overflow           (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":empty"},     32'(empty),       32'(q.size() == 0));
        chk({tag, ":overflow"},  32'(overflow),    32'(q.size() == CAP));
        chk({tag, ":read_data"}, 32'(read_data),   32'(last_read));
        chk({tag, ":wr_ptr"},    32'(dut.wr_ptr),  32'(wp));
        chk({tag, ":rd_ptr"},    32'(dut.rd_ptr),  32'(rp));
    endtask

    task automatic step(input string tag, input logic rst_n, input logic we,
                        input logic [DW-1:0] wd, input logic re);
        bit rd_ok;
        bit wr_ok;
        reset = rst_n;
        write_clock_enable = we;
        write_data = wd;
        read_clock_enable = re;
        @(posedge clock);
        if (!rst_n) begin
            q.delete();
            last_read = '0;
            wp = 0;
            rp = 0;
        end else begin
            rd_ok = re && (q.size() != 0);
            wr_ok = we && (q.size() < CAP);
            if (rd_ok) begin
                last_read = q.pop_front();
                rp = (rp + 1) % (1 << AW);
            end
            if (wr_ok) begin
                q.push_back(wd);
                wp = (wp + 1) % (1 << AW);
            end
        end
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        step("reset",        1'b0, 1'b0, 2'd0, 1'b0);
        step("rd_empty",     1'b1, 1'b0, 2'd0, 1'b1);
        step("wr_01",        1'b1, 1'b1, 2'd1, 1'b0);
        step("rd_01",        1'b1, 1'b0, 2'd0, 1'b1);
        chk("rd_01_literal", 32'(read_data), 32'd1);
        step("fill_1",       1'b1, 1'b1, 2'd1, 1'b0);
        step("fill_2",       1'b1, 1'b1, 2'd2, 1'b0);
        step("fill_3",       1'b1, 1'b1, 2'd3, 1'b0);
        chk("full_literal",  32'(overflow), 32'd1);
        step("drop_4th",     1'b1, 1'b1, 2'd0, 1'b0);
        step("drain_1",      1'b1, 1'b0, 2'd0, 1'b1);
        step("drain_2",      1'b1, 1'b0, 2'd0, 1'b1);
        step("drain_3",      1'b1, 1'b0, 2'd0, 1'b1);
        chk("drain_literal", 32'(read_data), 32'd3);
        step("one_word",     1'b1, 1'b1, 2'd2, 1'b0);
        step("rw_same",      1'b1, 1'b1, 2'd3, 1'b1);
        step("rw_next",      1'b1, 1'b0, 2'd0, 1'b1);
        step("rw_on_empty",  1'b1, 1'b1, 2'd1, 1'b1);
        step("rw_on_full_a", 1'b1, 1'b1, 2'd2, 1'b0);
        step("rw_on_full_b", 1'b1, 1'b1, 2'd3, 1'b0);
        step("rw_on_full",   1'b1, 1'b1, 2'd0, 1'b1);
        step("mid_reset",    1'b0, 1'b1, 2'd2, 1'b1);
        step("post_rst_wr",  1'b1, 1'b1, 2'd2, 1'b0);
        step("post_rst_rd",  1'b1, 1'b0, 2'd0, 1'b1);
        chk("post_rst_lit",  32'(read_data), 32'd2);

        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 49) != 0), 1'($urandom), DW'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_buffer.md
Name: ring_buffer

Overview:
- Single-clock circular FIFO of 2^AW entries, each DW bits wide.
- Sits between a producer (e.g. LPC decoder) and a slower consumer (e.g. UART drain) in the sniffer datapath.
- Uses the one-slot-sacrificed scheme: usable capacity is 2^AW-1 words.
- Exposes empty and overflow (full) status so the producer can throttle or flag lost data.

Parameters:
- AW, default 8: address width; storage depth 2^AW, usable capacity 2^AW-1.
- DW, default 8: data word width.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- write_data  input  DW  word to store.
- write_clock_enable  input  1  write request, sampled each rising edge.
- read_data  output  DW  registered output word, updated on an accepted read.
- read_clock_enable  input  1  read request, sampled each rising edge.
- empty  output  1  high when no words are stored.
- overflow  output  1  high when the buffer is full (2^AW-1 words stored).

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each AW bits, wrap modulo 2^AW.
  - Memory array of 2^AW x DW.
  - read_data register.
- Reset (reset==0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, read_data=0.
  - empty=1, overflow=0.
  - Memory contents are don't-care, not cleared.
  - Reset has priority over any concurrent request; contents written before reset are lost.
- Status flags, combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - overflow = (wr_ptr+1 mod 2^AW == rd_ptr).
  - overflow is a level, not sticky; it deasserts the cycle after any accepted read.
- Write accepted when write_clock_enable==1 and overflow==0 (pre-edge state):
  - mem[wr_ptr] <= write_data.
  - wr_ptr <= wr_ptr+1.
- Write while full: silently dropped; pointers and memory unchanged; overflow stays 1.
- Read accepted when read_clock_enable==1 and empty==0 (pre-edge state):
  - read_data <= mem[rd_ptr].
  - rd_ptr <= rd_ptr+1.
  - Latency: data is valid on read_data in the cycle after the accepted request.
- Read while empty:
  - Ignored; rd_ptr and read_data hold.
  - No underflow; no pointer movement.
- Simultaneous read and write: each is evaluated independently against pre-edge flags.
  - Neither empty nor full: both proceed; occupancy unchanged.
  - Empty: write proceeds, read ignored (no bypass); read_data holds.
  - Full: read proceeds, write dropped.
- Pointer wrap: pointers wrap from 2^AW-1 to 0 with no special handling.
- Enables held high for multiple cycles perform one transfer per cycle, subject to the rules above.
- read_data holds its last value between reads.

Decomposition:
- No shared package needed; AW/DW are module parameters.
- One natural sub-module: ring_buffer_mem, a simple dual-port RAM (one write port, one synchronous read port, same clock), inferable as block RAM.
- Pointer and flag logic stays in ring_buffer.

Test Plan:
- Reset, then read request on empty buffer (AW=2, DW=2): empty=1, overflow=0, read_data stays 0, rd_ptr stays 0.
- Write 2'b01, then read one cycle later: after write, empty=0 and overflow=0; after read, read_data=2'b01 and empty=1.
- From empty, write 1,2,3 on consecutive cycles: overflow=1 after the third write; a fourth write of 0 is dropped.
- Full buffer, read three times:
  - read_data sequence 1,2,3.
  - overflow=0 after the first read.
  - empty=1 after the third read.
  - Pointers have wrapped past 3.
- Simultaneous read+write with 1 word stored: occupancy stays 1, read_data = old word, the new word is read next.
- Assert reset mid-stream with 2 words stored: next edge gives empty=1, overflow=0, read_data=0; a subsequent write then read returns the newly written word.
